pe64_rr_arbiter: RTL and testbench

// Round-robin arbiter granting one of 64 requesters to a shared resource.

---
 rtl/pe64_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_pe64_rr_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pe64_rr_arbiter.sv
// Round-robin arbiter for 64 requesters using a two-cycle 16x4 priority encode.
// Each grant is held until the holder releases it or the hold timeout expires.
module pe64_rr_arbiter #(
  parameter int NREQ     = 64,
  parameter int IDX_W    = 6,
  parameter int MAX_HOLD = 255,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             gnt_release,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [NREQ-1:0]  gnt_onehot,
  output logic             busy,
  output logic             timeout
);

  localparam int NROW = 16;
  localparam int NCOL = 4;

  typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL, S_BUSY} state_t;

  state_t             state, state_nxt;
  logic [NREQ-1:0]    snap;
  logic [NREQ-1:0]    mask;
  logic [NREQ-1:0]    masked;
  logic [NREQ-1:0]    sel;
  logic [NROW-1:0]    row_or;
  logic [3:0]         row_hi;
  logic [NCOL-1:0]    row_sel;
  logic [3:0]         row_idx;
  logic [NCOL-1:0]    row_bits;
  logic [1:0]         col_hi;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [IDX_W-1:0]   last_ptr;
  logic               hold_expired;

  // Only requesters strictly below the last grant compete first; wrap to all otherwise.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    mask    = (NREQ'(1) << last_ptr) - NREQ'(1);
    masked  = snap & mask;
    sel     = (|masked) ? masked : snap;
    row_hi  = '0;
    for (int r = 0; r < NROW; r++) begin
      row_or[r] = |sel[NCOL*r +: NCOL];
      if (row_or[r]) row_hi = 4'(r);
    end
    row_sel = sel[NCOL*int'(row_hi) +: NCOL];
    col_hi  = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (row_bits[c]) col_hi = 2'(c);
    end
  end

  assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign busy         = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_ROW;
      S_ROW:   state_nxt = S_COL;
      S_COL:   state_nxt = S_BUSY;
      S_BUSY:  if (gnt_release || hold_expired) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap       <= '0;
      row_idx    <= '0;
      row_bits   <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      hold_cnt   <= '0;
      last_ptr   <= '0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: if (|req) snap <= req;
        S_ROW: begin
          row_idx  <= row_hi;
          row_bits <= row_sel;
        end
        S_COL: begin
          gnt_idx    <= {row_idx, col_hi};
          gnt_onehot <= NREQ'(1) << {row_idx, col_hi};
          gnt_valid  <= 1'b1;
          hold_cnt   <= '0;
        end
        S_BUSY: begin
          if (gnt_release || hold_expired) begin
            last_ptr   <= gnt_idx;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            // A release coinciding with expiry is a normal release.
            timeout    <= !gnt_release;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe64_rr_arbiter.sv
// Directed bench for pe64_rr_arbiter: latency, rotation/wrap, hold timeout, reset.
module tb_pe64_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] req;
  logic        gnt_release;
  logic        gnt_valid;
  logic [5:0]  gnt_idx;
  logic [63:0] gnt_onehot;
  logic        busy;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  pe64_rr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .gnt_release(gnt_release),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (!gnt_valid && n < 8) begin
      tick();
      n++;
    end
  endtask

  task automatic expect_grant(input string tag, input int exp_idx);
    int n;
    wait_grant(n);
    check({tag, "_valid"}, gnt_valid, 1'b1);
    check({tag, "_idx"}, gnt_idx, exp_idx);
    check({tag, "_onehot"}, gnt_onehot, 64'd1 << exp_idx);
  endtask

  task automatic release_grant(input string tag);
    gnt_release = 1'b1;
    tick();
    gnt_release = 1'b0;
    check({tag, "_rel_valid"}, {gnt_valid, busy, timeout}, 3'b000);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {gnt_valid, busy, timeout, gnt_idx}, '0);
    check({tag, "_onehot"}, gnt_onehot, '0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; req = '0; gnt_release = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle", {gnt_valid, busy, gnt_idx}, '0);
    end

    // Single requester 0: three edges to grant.
    req = 64'h1;
    tick();
    check("lat_e0_busy", {busy, gnt_valid}, 2'b10);
    tick();
    check("lat_e1_valid", gnt_valid, 1'b0);
    tick();
    check("lat_e2_valid", gnt_valid, 1'b1);
    check("req0_idx", gnt_idx, 0);
    check("req0_onehot", gnt_onehot, 64'h1);
    req = '0;
    release_grant("req0");

    // All requesting: descending order then wrap to 63.
    req = '1;
    for (int k = 63; k >= 0; k--) begin
      expect_grant($sformatf("rot%0d", k), k);
      release_grant($sformatf("rot%0d", k));
    end
    expect_grant("wrap", 63);
    release_grant("wrap");

    // Establish last_ptr=40, then {5,40} alternates.
    req = 64'd1 << 40;
    expect_grant("set40", 40);
    release_grant("set40");
    req = (64'd1 << 40) | (64'd1 << 5);
    expect_grant("pair_a", 5);
    release_grant("pair_a");
    expect_grant("pair_b", 40);
    release_grant("pair_b");
    expect_grant("pair_c", 5);
    release_grant("pair_c");

    // Hold timeout on requester 17; new requests ignored while busy.
    req = 64'd1 << 17;
    expect_grant("hold17", 17);
    req = (64'd1 << 17) | (64'd1 << 30) | (64'd1 << 3);
    for (int i = 0; i < 254; i++) tick();
    check("hold_last", {gnt_valid, timeout, gnt_idx}, {2'b10, 6'd17});
    tick();
    check("timeout_pulse", {gnt_valid, busy, timeout}, 3'b001);
    tick();
    check("timeout_clear", {timeout, busy}, 2'b01);
    expect_grant("after_to", 3);
    release_grant("after_to");

    // Release on the expiry cycle: no timeout pulse.
    req = 64'd1 << 10;
    expect_grant("edge10", 10);
    for (int i = 0; i < 254; i++) tick();
    check("edge_still", gnt_valid, 1'b1);
    gnt_release = 1'b1;
    tick();
    gnt_release = 1'b0;
    check("edge_notimeout", {gnt_valid, busy, timeout}, 3'b000);

    // Release while idle is ignored.
    req = '0;
    tick();
    gnt_release = 1'b1;
    tick();
    gnt_release = 1'b0;
    tick();
    check_all_zero("rel_idle");

    // Reset in S_COL.
    req = '1;
    tick(); tick();
    check("in_col", {busy, gnt_valid}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst_col");
    expect_grant("post_rst_col", 63);
    release_grant("post_rst_col");

    // Reset in S_BUSY.
    expect_grant("pre_rst_busy", 62);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst_busy");
    wait_grant(n);
    check("post_rst_lat", n, 3);
    check("post_rst_busy_idx", gnt_idx, 63);
    release_grant("post_rst_busy");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
